sgpio_master: RTL and testbench
===============================

Name: sgpio_master

Overview:
- Master side of the 4-wire synchronous serial link (sclk, sync, mosi, miso); sits directly upstream of the board-side SGPIO slave and drives it.
- Runs on the FPGA system clock and divides it down to produce sclk.
- Each frame it sends an 8-bit switch word to the slave LSB-first and receives the slave's 8-bit LED word LSB-first.
- Frames run back-to-back while enabled.

Parameters:
- CLK_DIV, 4: i_clk cycles per sclk half-period; legal range 2..255 (3..255 when the optional synchronizer is compiled in).
- DATA_W, 8: bits per frame in each direction.

Ports:
- i_clk  in  1  system clock
- i_rstn  in  1  asynchronous active-low reset
- i_en  in  1  1 = run frames continuously; 0 = stop at the end of the current frame
- i_user_sw  in  DATA_W  word to send to the slave; sampled at the start of each frame
- o_user_led  out  DATA_W  last complete word received from the slave
- o_user_led_valid  out  1  sticky; goes to 1 after the first complete frame
- o_frame_done  out  1  one-i_clk pulse when o_user_led updates
- o_sclk  out  1  serial clock
- o_sync  out  1  frame start; high for exactly one sclk cycle per frame
- o_mosi  out  1  serial data to the slave
- i_miso  in  1  serial data from the slave

Behaviour:
- Reset (async assert, sync release), all outputs 0: o_sclk, o_sync, o_mosi, o_user_led, o_user_led_valid, o_frame_done. State = IDLE, counters = 0.
- sclk cycle: low half, then high half, each CLK_DIV i_clk cycles. The slave samples on the rising edge at mid-cycle. o_sync and o_mosi change only at the start of a low half.
- Frame: DATA_W+1 sclk cycles, indexed k = 0..DATA_W.
  - k=0: o_sync=1, o_mosi=0; i_user_sw captured into the tx shift register.
  - k=1..DATA_W: o_sync=0, o_mosi = tx[k-1].
- MISO sampling: i_miso is sampled at the end of sclk cycles k=0..DATA_W-1, i.e. the i_clk cycle before the falling edge, and shifted right into the rx register (new bit enters at the MSB). This yields LED bits 0..DATA_W-1, LSB-first.
- At the end of cycle k=DATA_W-1:
  - o_user_led <= rx register;
  - o_frame_done pulses for one i_clk;
  - o_user_led_valid <= 1.
- Cycle k=DATA_W: still drives the last mosi bit; miso is ignored.
- Pipeline consequence: the slave presents the switch word of frame N only at the sync edge of frame N+1. Its own valid flag needs 2 sync edges.
- State machine:
  - IDLE: sclk held 0. When i_en=1, go to SYNC at the next i_clk.
  - SYNC (k=0) -> DATA.
  - DATA: bit counter 1..DATA_W. After cycle DATA_W, go to SYNC if i_en=1, else IDLE.
  - No gap between consecutive frames.
- i_en dropping mid-frame: the frame completes, then the block goes to IDLE. i_user_sw changes mid-frame have no effect until the next k=0.
- Reset mid-frame: immediate return to reset values. o_user_led is cleared and o_user_led_valid drops.
- Counter widths: divider ceil(log2(CLK_DIV)); bit counter ceil(log2(DATA_W+1)). No wrap except the explicit reloads.

Optional Feature:
- Macro: SGPIO_MASTER_MISO_SYNC_EN.
- Defined:
  - i_miso passes a 2-flop synchronizer on i_clk.
  - The sample strobe is delayed by 2 i_clk cycles, into the following low half, so sampled bit values are identical to the undefined case.
  - Requires CLK_DIV >= 3; an elaboration-time check rejects smaller values.
- Undefined: i_miso is sampled directly, with no added latency.

Decomposition:
- Package sgpio_pkg:
  - state enum (IDLE, SYNC, DATA);
  - default CLK_DIV and DATA_W constants;
  - frame length constant DATA_W+1.
- One sub-module: sgpio_clk_gen, the divider producing o_sclk, a rise strobe, a fall strobe and a sample strobe, with an enable input. The frame FSM and shift registers stay in sgpio_master.

Test Plan:
- Reset then i_en=1, CLK_DIV=4, i_user_sw=8'hA5:
  - o_sync is high for exactly 8 i_clk (one sclk cycle);
  - mosi bits at the following 8 rising edges are 1,0,1,0,0,1,0,1;
  - sclk period is 8 i_clk.
- Loopback against the slave model with i_user_led=8'h3C and i_user_sw=8'h81:
  - after frame 1, o_user_led=8'h3C and o_frame_done pulses once;
  - the slave's o_user_sw=8'h81 and its valid flag are set at the frame-2 sync edge.
- i_en dropped during bit 3: the frame finishes all DATA_W+1 cycles, then o_sclk stays 0, no further o_sync, and o_user_led holds.
- i_user_sw changed from 8'h0F to 8'hF0 mid-frame: the current frame still shifts 8'h0F; the next frame shifts 8'hF0.
- i_rstn pulsed low mid-frame: all outputs go to 0 asynchronously, o_user_led_valid=0, and a clean full frame starts after release.
- With SGPIO_MASTER_MISO_SYNC_EN defined and CLK_DIV=3, repeat the loopback test: identical o_user_led values.

Source files
------------

// File: rtl/sgpio_pkg.sv
// Shared types and default constants for the SGPIO master.
package sgpio_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2
    } state_e;

    localparam int DEF_CLK_DIV   = 4;
    localparam int DEF_DATA_W    = 8;
    localparam int DEF_FRAME_LEN = DEF_DATA_W + 1;

    // One sync cycle followed by DATA_W data cycles.
    function automatic int frame_len(input int data_w);
        return data_w + 1;
    endfunction

endpackage

// File: rtl/sgpio_clk_gen.sv
// sclk divider: low half then high half, CLK_DIV i_clk cycles each, with rise/fall/sample strobes.
// SGPIO_MASTER_MISO_SYNC_EN delays the sample strobe by 2 i_clk to match the miso synchronizer.
module sgpio_clk_gen
    import sgpio_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_en,
    output logic o_sclk,
    output logic o_rise,
    output logic o_fall,
    output logic o_sample
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_div
        $error("sgpio_clk_gen: CLK_DIV must be in 2..255");
    end

    logic [DIV_W-1:0] div_q, div_d;
    logic             sclk_q, sclk_d;
    logic             half_end;

    assign half_end = i_en && (div_q == DIV_W'(CLK_DIV - 1));

    // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        div_d  = div_q;
        sclk_d = sclk_q;
        if (!i_en) begin
            div_d  = '0;
            sclk_d = 1'b0;
        end else if (half_end) begin
            div_d  = '0;
            sclk_d = ~sclk_q;
        end else begin
            div_d  = div_q + DIV_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            div_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            sclk_q <= sclk_d;
        end
    end

    assign o_sclk = sclk_q;
    assign o_rise = half_end && !sclk_q;
    assign o_fall = half_end && sclk_q;

`ifdef SGPIO_MASTER_MISO_SYNC_EN
    if (CLK_DIV < 3) begin : g_bad_sync_div
        $error("sgpio_clk_gen: CLK_DIV must be >= 3 with the miso synchronizer");
    end

    logic [1:0] smp_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) smp_q <= '0;
        else         smp_q <= {smp_q[0], o_fall};
    end

    assign o_sample = smp_q[1];
`else
    assign o_sample = o_fall;
`endif

endmodule

// File: rtl/sgpio_master.sv
// SGPIO link master: frame FSM, tx/rx shift registers and LED word capture.
// Optional SGPIO_MASTER_MISO_SYNC_EN adds a 2-flop synchronizer on i_miso (requires CLK_DIV >= 3).
module sgpio_master
    import sgpio_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int DATA_W  = DEF_DATA_W
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_user_sw,
    output logic [DATA_W-1:0] o_user_led,
    output logic              o_user_led_valid,
    output logic              o_frame_done,
    output logic              o_sclk,
    output logic              o_sync,
    output logic              o_mosi,
    input  logic              i_miso
);

    localparam int CNT_W = $clog2(frame_len(DATA_W));

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  bit_q, bit_d;
    logic [DATA_W-1:0] tx_q, tx_d, rx_q, rx_d, led_q, led_d;
    logic              valid_q, valid_d, done_q, done_d;
    logic              take_q, take_d, last_q, last_d;
    logic              clk_en, rise, fall, sample, miso_s;

    sgpio_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .i_en     (clk_en),
        .o_sclk   (o_sclk),
        .o_rise   (rise),
        .o_fall   (fall),
        .o_sample (sample)
    );

`ifdef SGPIO_MASTER_MISO_SYNC_EN
    logic miso_meta_q, miso_sync_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            miso_meta_q <= 1'b0;
            miso_sync_q <= 1'b0;
        end else begin
            miso_meta_q <= i_miso;
            miso_sync_q <= miso_meta_q;
        end
    end

    assign miso_s = miso_sync_q;
`else
    assign miso_s = i_miso;
`endif

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= IDLE;
            bit_q   <= '0;
            tx_q    <= '0;
            rx_q    <= '0;
            led_q   <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            take_q  <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
            rx_q    <= rx_d;
            led_q   <= led_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            take_q  <= take_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        tx_d    = tx_q;
        rx_d    = rx_q;
        led_d   = led_q;
        valid_d = valid_q;
        done_d  = 1'b0;
        take_d  = take_q;
        last_d  = last_q;

        case (state_q)
            IDLE: begin
                if (i_en) begin
                    state_d = SYNC;
                    bit_d   = '0;
                    tx_d    = i_user_sw;
                end
            end
            SYNC: begin
                if (fall) begin
                    state_d = DATA;
                    bit_d   = CNT_W'(1);
                end
            end
            DATA: begin
                if (fall) begin
                    if (bit_q == CNT_W'(DATA_W)) begin
                        bit_d   = '0;
                        state_d = i_en ? SYNC : IDLE;
                        if (i_en) tx_d = i_user_sw;
                    end else begin
                        bit_d = bit_q + CNT_W'(1);
                        tx_d  = tx_q >> 1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Tag each sclk cycle at its rise so a (possibly delayed) sample knows which bit it holds.
        if (rise) begin
            take_d = (bit_q < CNT_W'(DATA_W));
            last_d = (bit_q == CNT_W'(DATA_W - 1));
        end

        if (sample && take_q) begin
            rx_d = {miso_s, rx_q[DATA_W-1:1]};
            if (last_q) begin
                led_d   = rx_d;
                valid_d = 1'b1;
                done_d  = 1'b1;
            end
        end
    end

    always_comb begin
        clk_en = (state_q != IDLE);
        o_sync = (state_q == SYNC);
        o_mosi = (state_q == DATA) && tx_q[0];
    end

    assign o_user_led       = led_q;
    assign o_user_led_valid = valid_q;
    assign o_frame_done     = done_q;

endmodule

// File: tb/tb_sgpio_master.sv
// Directed bench for sgpio_master with a behavioural SGPIO slave on the far end of the link.
module tb_sgpio_master;

`ifdef SGPIO_MASTER_MISO_SYNC_EN
    localparam int C = 3;
`else
    localparam int C = 4;
`endif
    localparam int DW    = 8;
    localparam int LIMIT = 1000;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          en = 1'b0;
    logic [DW-1:0] sw = '0;
    logic [DW-1:0] led;
    logic          led_valid, frame_done, sclk, sync, mosi;
    logic          miso = 1'b0;

    logic [DW-1:0] s_led = '0;
    logic [DW-1:0] s_sw, s_rx, s_tx;
    logic          s_valid;
    int            s_cnt;

    int checks = 0;
    int errors = 0;

    sgpio_master #(.CLK_DIV(C), .DATA_W(DW)) dut (
        .i_clk            (clk),
        .i_rstn           (rstn),
        .i_en             (en),
        .i_user_sw        (sw),
        .o_user_led       (led),
        .o_user_led_valid (led_valid),
        .o_frame_done     (frame_done),
        .o_sclk           (sclk),
        .o_sync           (sync),
        .o_mosi           (mosi),
        .i_miso           (miso)
    );

    always #5 clk = ~clk;

    // Slave: samples sync/mosi on sclk rise, presents LED bits LSB-first starting at the sync rise.
    always @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            s_cnt = 0; s_rx = '0; s_tx = '0; s_sw = '0; s_valid = 1'b0; miso = 1'b0;
        end else begin
            #1;
            if (sync) begin
                if (s_cnt == DW) begin
                    s_sw    = s_rx;
                    s_valid = 1'b1;
                end
                s_cnt = 0;
                s_tx  = s_led;
                miso  = s_led[0];
            end else begin
                s_rx = {mosi, s_rx[DW-1:1]};
                if (s_cnt < DW) s_cnt++;
                s_tx = s_tx >> 1;
                miso = s_tx[0];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_sync_high(input string tag);
        int n = 0;
        while (sync !== 1'b1 && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        chk(tag, sync, 1);
    endtask

    task automatic sync_len(output int n);
        n = 0;
        while (sync === 1'b1 && n < LIMIT) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic wait_rise(output int n);
        logic prev;
        bit   seen;
        seen = 1'b0;
        n    = 0;
        prev = sclk;
        while (!seen && n < LIMIT) begin
            @(negedge clk);
            n++;
            seen = (prev === 1'b0 && sclk === 1'b1);
            prev = sclk;
        end
        if (!seen) begin
            checks++;
            errors++;
            $error("FAIL sclk_rise_timeout observed=none expected=rise");
        end
    endtask

    task automatic collect_word(input bit chg, output logic [DW-1:0] w, output int gap);
        for (int i = 0; i < DW; i++) begin
            wait_rise(gap);
            w[i] = mosi;
            if (chg && i == 2) sw = 8'hF0;
        end
    endtask

    initial begin
        int            n;
        int            gap;
        int            n_done;
        int            n_rise;
        int            n_sync;
        logic          prev;
        logic [DW-1:0] w;
        logic [DW-1:0] cap;

        // Reset values, then a plain frame of 8'hA5.
        sw = 8'hA5;
        tick(2);
        chk("rst_sclk", sclk, 0);
        chk("rst_sync", sync, 0);
        chk("rst_mosi", mosi, 0);
        chk("rst_led", led, 0);
        chk("rst_valid", led_valid, 0);
        chk("rst_done", frame_done, 0);
        rstn = 1'b1;
        en   = 1'b1;
        wait_sync_high("t1_sync_seen");
        sync_len(n);
        chk("t1_sync_len", n, 2 * C);
        collect_word(1'b0, w, gap);
        chk("t1_mosi_word", w, 8'hA5);
        chk("t1_sclk_period", gap, 2 * C);

        // Loopback against the slave: LED 8'h3C back, switch 8'h81 out.
        rstn = 1'b0;
        en = 1'b1; sw = 8'h81; s_led = 8'h3C;
        tick(2);
        rstn = 1'b1;
        n_done = 0;
        cap = '0;
        for (int i = 0; i < (DW + 1) * 2 * C + 2; i++) begin
            @(negedge clk);
            if (frame_done) begin
                n_done++;
                cap = led;
            end
        end
        chk("t2_done_pulses", n_done, 1);
        chk("t2_led_at_done", cap, 8'h3C);
        chk("t2_led_valid", led_valid, 1);
        chk("t2_slave_valid_early", s_valid, 0);
        wait_rise(n);
        chk("t2_frame2_sync_rise", sync, 1);
        chk("t2_slave_sw", s_sw, 8'h81);
        chk("t2_slave_valid", s_valid, 1);

        // Drop i_en during bit 3 of frame 2.
        sync_len(n);
        tick(5 * C + 1);
        en = 1'b0;
        n_rise = 0; n_sync = 0; n_done = 0;
        prev = sclk;
        for (int i = 0; i < 20 * C; i++) begin
            @(negedge clk);
            if (prev === 1'b0 && sclk === 1'b1) n_rise++;
            if (sync) n_sync++;
            if (frame_done) n_done++;
            prev = sclk;
        end
        chk("t3_remaining_rises", n_rise, 5);
        chk("t3_no_sync", n_sync, 0);
        chk("t3_done_pulses", n_done, 1);
        chk("t3_sclk_idle", sclk, 0);
        chk("t3_led_hold", led, 8'h3C);
        chk("t3_valid_hold", led_valid, 1);

        // Mid-frame switch change only takes effect at the next frame.
        sw = 8'h0F;
        en = 1'b1;
        wait_sync_high("t4_sync1_seen");
        sync_len(n);
        collect_word(1'b1, w, gap);
        chk("t4_frame1_word", w, 8'h0F);
        wait_sync_high("t4_sync2_seen");
        sync_len(n);
        collect_word(1'b0, w, gap);
        chk("t4_frame2_word", w, 8'hF0);

        // Asynchronous reset in the middle of a frame.
        sw = 8'hFF;
        wait_sync_high("t5_sync_seen");
        sync_len(n);
        wait_rise(n);
        tick(1);
        chk("t5_pre_sclk", sclk, 1);
        chk("t5_pre_mosi", mosi, 1);
        rstn = 1'b0;
        #1;
        chk("t5_rst_sclk", sclk, 0);
        chk("t5_rst_sync", sync, 0);
        chk("t5_rst_mosi", mosi, 0);
        chk("t5_rst_led", led, 0);
        chk("t5_rst_valid", led_valid, 0);
        chk("t5_rst_done", frame_done, 0);
        tick(2);
        rstn = 1'b1;
        chk("t5_rel_led", led, 0);
        chk("t5_rel_valid", led_valid, 0);
        wait_sync_high("t5_resync_seen");
        sync_len(n);
        chk("t5_sync_len", n, 2 * C);
        collect_word(1'b0, w, gap);
        chk("t5_mosi_word", w, 8'hFF);
        chk("t5_led_after", led, 8'h3C);
        chk("t5_valid_after", led_valid, 1);

        en = 1'b0;
        tick(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
